// File: rtl/noncon_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noncon_responder: accepts a request, emits n non-consecutive busy pulses,  |
// | then a one-cycle grant after d idle cycles. Optional SVA: NONCON_RESP_SVA_EN|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module noncon_responder #(
  parameter int CFG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [CFG_W-1:0] busy_pulses,
  input  logic [CFG_W-1:0] gnt_delay,
  output logic             busy,
  output logic             gnt,
  output logic             active,
  output logic [CNT_W-1:0] txn_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GAP  = 3'd1,
    HI   = 3'd2,
    WAIT = 3'd3,
    GNT  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CFG_W-1:0] r_n;
  logic [CFG_W-1:0] r_d;
  logic [CFG_W-1:0] r_pulses;
  logic [CFG_W-1:0] r_waits;
  logic [CFG_W-1:0] w_n_nxt;
  logic [CFG_W-1:0] w_d_nxt;
  logic [CFG_W-1:0] w_pulses_nxt;
  logic [CFG_W-1:0] w_waits_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_n_nxt      = r_n;
    w_d_nxt      = r_d;
    w_pulses_nxt = r_pulses;
    w_waits_nxt  = r_waits;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_n_nxt      = busy_pulses;
          w_d_nxt      = gnt_delay;
          w_pulses_nxt = '0;
          w_waits_nxt  = '0;
          if (busy_pulses != '0)
            w_state_nxt = GAP;
          else if (gnt_delay != '0)
            w_state_nxt = WAIT;
          else
            w_state_nxt = GNT;
        end
      end
      GAP: w_state_nxt = HI;
      HI: begin
        // Counters run up toward the latched targets so late config edits cannot leak in.
        w_pulses_nxt = r_pulses + 1'b1;
        if (w_pulses_nxt != r_n)
          w_state_nxt = GAP;
        else if (r_d != '0)
          w_state_nxt = WAIT;
        else
          w_state_nxt = GNT;
      end
      WAIT: begin
        w_waits_nxt = r_waits + 1'b1;
        if (w_waits_nxt == r_d)
          w_state_nxt = GNT;
      end
      GNT:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_n      <= '0;
      r_d      <= '0;
      r_pulses <= '0;
      r_waits  <= '0;
      busy     <= 1'b0;
      gnt      <= 1'b0;
      active   <= 1'b0;
      txn_cnt  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_n      <= w_n_nxt;
      r_d      <= w_d_nxt;
      r_pulses <= w_pulses_nxt;
      r_waits  <= w_waits_nxt;
      busy     <= (w_state_nxt == HI);
      gnt      <= (w_state_nxt == GNT);
      active   <= (w_state_nxt != IDLE);
      if (r_state == GNT)
        txn_cnt <= txn_cnt + 1'b1;
    end
  end

`ifdef NONCON_RESP_SVA_EN
  // Busy pulses seen since acceptance; must equal the latched n when gnt fires.
  logic [CFG_W-1:0] r_sva_busy_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sva_busy_seen <= '0;
    else if (r_state == IDLE && req)
      r_sva_busy_seen <= '0;
    else if (busy)
      r_sva_busy_seen <= r_sva_busy_seen + 1'b1;
  end

  a_pulses_before_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    gnt |-> (r_sva_busy_seen == r_n));
  a_gnt_single: assert property (@(posedge clk) disable iff (!rst_n)
    gnt |=> !gnt);
  a_busy_noncons: assert property (@(posedge clk) disable iff (!rst_n)
    busy |=> !busy);
  a_busy_gnt_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(busy && gnt));
`endif

endmodule
`default_nettype wire

// File: tb/tb_noncon_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_noncon_responder: table vectors, directed corner sequences and random   |
// | traffic against a cycle-arithmetic reference model. Revision: 1.0          |
// +----------------------------------------------------------------------------+
module tb_noncon_responder;
  localparam int CFG_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req;
  logic [CFG_W-1:0] busy_pulses;
  logic [CFG_W-1:0] gnt_delay;
  logic             busy;
  logic             gnt;
  logic             active;
  logic [CNT_W-1:0] txn_cnt;

  always #5 clk = ~clk;

  noncon_responder #(.CFG_W(CFG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .busy_pulses(busy_pulses),
    .gnt_delay(gnt_delay), .busy(busy), .gnt(gnt), .active(active),
    .txn_cnt(txn_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: one transaction described by its acceptance cycle t0 and latched n, d.
  bit              m_valid = 1'b0;
  int              m_t0 = 0;
  int              m_n = 0;
  int              m_d = 0;
  logic [CNT_W-1:0] m_cnt = '0;

  int          rec_base = 0;
  logic [63:0] rec_busy, rec_gnt, rec_act;

  typedef struct {
    int          n;
    int          d;
    logic [63:0] busy_m;
    logic [63:0] gnt_m;
    logic [63:0] act_m;
  } vec_t;
  vec_t vecs[7];

  function automatic int gnt_cycle();
    return m_t0 + 2 * m_n + 1 + m_d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    int k;
    int idx;
    bit eb = 1'b0;
    bit eg = 1'b0;
    bit ea = 1'b0;
    if (m_valid) begin
      k  = cyc - m_t0;
      eb = (k >= 2) && (k <= 2 * m_n) && (k % 2 == 0);
      eg = (k == 2 * m_n + 1 + m_d);
      ea = (k >= 1) && (k <= 2 * m_n + 1 + m_d);
    end
    check("busy", 64'(busy), 64'(eb));
    check("gnt", 64'(gnt), 64'(eg));
    check("active", 64'(active), 64'(ea));
    check("txn_cnt", 64'(txn_cnt), 64'(m_cnt));
    idx = cyc - rec_base;
    if (idx >= 0 && idx < 64) begin
      rec_busy[idx] = busy;
      rec_gnt[idx]  = gnt;
      rec_act[idx]  = active;
    end
  endtask

  // Inputs for the current cycle are already applied; advance one edge and check.
  task automatic tick();
    if (!rst_n) begin
      m_valid = 1'b0;
      m_cnt   = '0;
    end else begin
      if (m_valid && cyc == gnt_cycle())
        m_cnt = m_cnt + 1'b1;
      if ((!m_valid || cyc > gnt_cycle()) && req) begin
        m_valid = 1'b1;
        m_t0    = cyc;
        m_n     = int'(busy_pulses);
        m_d     = int'(gnt_delay);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic start_rec();
    rec_base = cyc;
    rec_busy = '0;
    rec_gnt  = '0;
    rec_act  = '0;
  endtask

  // Pulse req in the current cycle (cycle 0), then run until cycle len.
  task automatic run_txn(input int n, input int d, input int len);
    busy_pulses = CFG_W'(n);
    gnt_delay   = CFG_W'(d);
    req         = 1'b1;
    start_rec();
    tick();
    req         = 1'b0;
    busy_pulses = CFG_W'($urandom);
    gnt_delay   = CFG_W'($urandom);
    repeat (len - 1) tick();
  endtask

  initial begin
    vecs[0] = '{3, 0, 64'h54, 64'h80, 64'hFE};
    vecs[1] = '{3, 5, 64'h54, 64'h1000, 64'h1FFE};
    vecs[2] = '{0, 2, 64'h0, 64'h8, 64'hE};
    vecs[3] = '{1, 0, 64'h4, 64'h8, 64'hE};
    vecs[4] = '{0, 0, 64'h0, 64'h2, 64'h2};
    vecs[5] = '{2, 1, 64'h14, 64'h40, 64'h7E};
    vecs[6] = '{15, 15, 64'h5555_5554, 64'h0000_4000_0000_0000, 64'h0000_7FFF_FFFF_FFFE};

    rst_n = 1'b0;
    req = 1'b0;
    busy_pulses = '0;
    gnt_delay = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_txn(vecs[i].n, vecs[i].d, 50);
      check($sformatf("vec%0d_busy", i), rec_busy, vecs[i].busy_m);
      check($sformatf("vec%0d_gnt", i), rec_gnt, vecs[i].gnt_m);
      check($sformatf("vec%0d_active", i), rec_act, vecs[i].act_m);
    end
    check("cnt_after_table", 64'(txn_cnt), 64'd7);

    // req held high: only the cycle after each GNT may accept.
    busy_pulses = 4'd1;
    gnt_delay = 4'd0;
    req = 1'b1;
    start_rec();
    repeat (12) tick();
    req = 1'b0;
    repeat (3) tick();
    check("held_gnt", rec_gnt, 64'h888);
    check("held_busy", rec_busy, 64'h444);

    // Reset in cycle 5 of an n=3 transaction, then a clean transaction after release.
    run_txn(3, 0, 5);
    check("pre_rst_active", 64'(active), 64'd1);
    #2;
    rst_n = 1'b0;
    m_valid = 1'b0;
    m_cnt = '0;
    #1;
    check("rst_async_busy", 64'(busy), 64'd0);
    check("rst_async_gnt", 64'(gnt), 64'd0);
    check("rst_async_active", 64'(active), 64'd0);
    check("rst_async_cnt", 64'(txn_cnt), 64'd0);
    req = 1'b1;
    start_rec();
    repeat (2) tick();
    check("rst_no_gnt", rec_gnt | rec_act, 64'd0);
    rst_n = 1'b1;
    run_txn(3, 0, 8);
    check("post_rst_busy", rec_busy, 64'h54);
    check("post_rst_gnt", rec_gnt, 64'h80);
    check("post_rst_cnt", 64'(txn_cnt), 64'd1);
    repeat (3) tick();

    // Random traffic with config inputs changing freely.
    for (int i = 0; i < 400; i++) begin
      req         = ($urandom_range(0, 2) == 0);
      busy_pulses = CFG_W'($urandom_range(0, 6));
      gnt_delay   = CFG_W'($urandom_range(0, 5));
      tick();
    end
    req = 1'b0;
    repeat (40) tick();

    // Drive txn_cnt to 255 with minimal transactions, then wrap.
    busy_pulses = '0;
    gnt_delay = '0;
    for (int i = 0; i < 2000 && m_cnt != 8'd255; i++) begin
      req = 1'b1;
      tick();
    end
    req = 1'b0;
    tick();
    check("cnt_preset", 64'(txn_cnt), 64'd255);
    run_txn(0, 0, 4);
    check("cnt_wrap", 64'(txn_cnt), 64'd0);

    // Config change after acceptance must not alter the pulse count.
    busy_pulses = 4'd3;
    gnt_delay = 4'd0;
    req = 1'b1;
    start_rec();
    tick();
    req = 1'b0;
    tick();
    busy_pulses = 4'd7;
    gnt_delay = 4'd9;
    repeat (20) tick();
    check("cfg_change_pulses", 64'($countones(rec_busy)), 64'd3);
    check("cfg_change_gnt", rec_gnt, 64'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
